// File: rtl/execute_ctrl_pkg.sv
// execute_ctrl_pkg: shared state encoding and sizing helper for the execute-stage sequencer.
// Contents:
//   CTL_STATE_WIDTH, CTL_RUN, CTL_MEM_WAIT, CTL_FLUSH - FSM encoding seen on ctl_o_state
//   ctl_state_e                                       - typed FSM state
//   cnt_width()                                       - bits needed to count 0..n-1 (min 1)
package execute_ctrl_pkg;

    localparam int unsigned CTL_STATE_WIDTH = 2;

    localparam logic [CTL_STATE_WIDTH-1:0] CTL_RUN      = 2'd0;
    localparam logic [CTL_STATE_WIDTH-1:0] CTL_MEM_WAIT = 2'd1;
    localparam logic [CTL_STATE_WIDTH-1:0] CTL_FLUSH    = 2'd2;

    // Encoding 3 is left unnamed on purpose; the FSM treats it as illegal.
    typedef enum logic [CTL_STATE_WIDTH-1:0] {
        StRun     = CTL_RUN,
        StMemWait = CTL_MEM_WAIT,
        StFlush   = CTL_FLUSH
    } ctl_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/execute_ctrl_load_use_detect.sv
// execute_ctrl_load_use_detect: combinational load-use hazard compare.
// Ports:
//   load              - instruction in execute is a load
//   addr_rd           - destination register of that load
//   addr_rs1/addr_rs2 - source registers of the instruction in decode
//   use_rs1/use_rs2   - the corresponding source is really read
//   hazard            - decode needs a value the load has not produced yet
module execute_ctrl_load_use_detect #(
    parameter int unsigned AWIDTH = 5
) (
    input  logic              load,
    input  logic [AWIDTH-1:0] addr_rd,
    input  logic [AWIDTH-1:0] addr_rs1,
    input  logic [AWIDTH-1:0] addr_rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    output logic              hazard
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = use_rs1 && (addr_rs1 == addr_rd);
        rs2_match = use_rs2 && (addr_rs2 == addr_rd);
        // Register 0 is hardwired, so a load into it never creates a dependency.
        hazard    = load && (addr_rd != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/execute_ctrl.sv
// execute_ctrl: pipeline sequencer for the execute stage.
// Handles load-use bubbles, holds the pipe while a load/store waits for memory (with timeout),
// and runs a fixed-length flush plus PC redirect after a taken branch/jump.
// Ports:
//   ex_clk, ex_rst                  - clock, asynchronous active-low reset
//   de_i_*                          - decode-stage instruction info
//   ex_i_load, ex_i_addr_rd         - load in execute and its destination
//   ex_i_change_pc, ex_i_next_pc    - taken branch/jump and its target
//   ex_i_mem_req, mem_i_ack         - memory access start / completion
//   ctl_o_ce/stall/flush            - execute-stage controls
//   ctl_o_fetch_stall/decode_stall  - hold upstream stages
//   ctl_o_decode_flush              - invalidate decode
//   ctl_o_redirect, _redirect_pc    - one-cycle PC load pulse and held target
//   ctl_o_mem_timeout               - one-cycle pulse when memory never acked
//   ctl_o_state, ctl_o_stall_cnt    - FSM state and saturating decode-stall cycle count
module execute_ctrl
    import execute_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH       = 5,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic                       ex_clk,
    input  logic                       ex_rst,
    input  logic                       de_i_valid,
    input  logic [AWIDTH-1:0]          de_i_addr_rs1,
    input  logic [AWIDTH-1:0]          de_i_addr_rs2,
    input  logic                       de_i_use_rs1,
    input  logic                       de_i_use_rs2,
    input  logic                       ex_i_load,
    input  logic [AWIDTH-1:0]          ex_i_addr_rd,
    input  logic                       ex_i_change_pc,
    input  logic [PC_WIDTH-1:0]        ex_i_next_pc,
    input  logic                       ex_i_mem_req,
    input  logic                       mem_i_ack,
    output logic                       ctl_o_ce,
    output logic                       ctl_o_stall,
    output logic                       ctl_o_flush,
    output logic                       ctl_o_fetch_stall,
    output logic                       ctl_o_decode_stall,
    output logic                       ctl_o_decode_flush,
    output logic                       ctl_o_redirect,
    output logic [PC_WIDTH-1:0]        ctl_o_redirect_pc,
    output logic                       ctl_o_mem_timeout,
    output logic [CTL_STATE_WIDTH-1:0] ctl_o_state,
    output logic [15:0]                ctl_o_stall_cnt
);

    localparam int unsigned TW = cnt_width(MEM_TIMEOUT);
    localparam int unsigned FW = cnt_width(FLUSH_CYCLES);

    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    ctl_state_e          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
    logic                redirect_q, redirect_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic ce_c;
    logic stall_c;
    logic flush_c;
    logic decode_flush_c;
    logic upstream_stall_c;

    execute_ctrl_load_use_detect #(
        .AWIDTH(AWIDTH)
    ) u_load_use_detect (
        .load    (ex_i_load),
        .addr_rd (ex_i_addr_rd),
        .addr_rs1(de_i_addr_rs1),
        .addr_rs2(de_i_addr_rs2),
        .use_rs1 (de_i_use_rs1),
        .use_rs2 (de_i_use_rs2),
        .hazard  (hazard)
    );

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_d       = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        timeout_d        = 1'b0;
        ce_c             = 1'b0;
        stall_c          = 1'b0;
        flush_c          = 1'b0;
        decode_flush_c   = 1'b0;
        upstream_stall_c = 1'b0;

        case (state_q)
            StRun: begin
                ce_c             = de_i_valid && !hazard && !ex_i_change_pc && !ex_i_mem_req;
                flush_c          = ex_i_change_pc;
                decode_flush_c   = ex_i_change_pc;
                upstream_stall_c = (hazard || ex_i_mem_req) && !ex_i_change_pc;
                // A hazard needs no state: execute drops its opcode while ce=0, so it clears.
                if (ex_i_change_pc) begin
                    state_d       = StFlush;
                    flush_cnt_d   = FLUSH_LAST;
                    redirect_d    = 1'b1;
                    redirect_pc_d = ex_i_next_pc;
                end else if (ex_i_mem_req) begin
                    state_d = StMemWait;
                    timer_d = '0;
                end
            end
            StMemWait: begin
                stall_c          = 1'b1;
                upstream_stall_c = 1'b1;
                // Ack wins over a coinciding timeout, so no pulse in that case.
                if (mem_i_ack) begin
                    state_d = StRun;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = StRun;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StFlush: begin
                flush_c        = 1'b1;
                decode_flush_c = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (upstream_stall_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ex_clk or negedge ex_rst) begin
        if (!ex_rst) begin
            state_q       <= StRun;
            timer_q       <= '0;
            flush_cnt_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            timeout_q     <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            timeout_q     <= timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held, whatever the inputs do.
    always_comb begin
        ctl_o_ce           = ex_rst && ce_c;
        ctl_o_stall        = ex_rst && stall_c;
        ctl_o_flush        = ex_rst && flush_c;
        ctl_o_decode_flush = ex_rst && decode_flush_c;
        ctl_o_fetch_stall  = ex_rst && upstream_stall_c;
        ctl_o_decode_stall = ex_rst && upstream_stall_c;
        ctl_o_redirect     = redirect_q;
        ctl_o_redirect_pc  = redirect_pc_q;
        ctl_o_mem_timeout  = timeout_q;
        ctl_o_state        = state_q;
        ctl_o_stall_cnt    = stall_cnt_q;
    end

endmodule

// File: doc/execute_ctrl.md
# execute_ctrl

Pipeline sequencer for the execute stage. Drives the execute stage's `ex_i_ce`, `ex_i_stall` and `ex_i_flush` and stalls fetch and decode. It detects load-use hazards, holds the pipeline while a load/store waits for memory (with a timeout), and runs a fixed-length flush with a PC redirect after a taken branch or jump. It sits between decode, execute and the memory interface, next to the execute stage.

## Interface
- `AWIDTH`, 5, register address width
- `PC_WIDTH`, 32, PC width
- `FLUSH_CYCLES`, 2, cycles `ctl_o_flush` stays high per redirect (≥1)
- `MEM_TIMEOUT`, 15, max wait cycles for `mem_i_ack` (≥1)

Ports:
- `ex_clk`  in  1  clock
- `ex_rst`  in  1  reset: asynchronous, active-low
- `de_i_valid`  in  1  decode holds an instruction
- `de_i_addr_rs1`, `de_i_addr_rs2`  in  AWIDTH  source registers of the decode instruction
- `de_i_use_rs1`, `de_i_use_rs2`  in  1  source actually read
- `ex_i_load`  in  1  instruction now in execute output is a load (`ex_o_opcode[LOAD_WORD]`)
- `ex_i_addr_rd`  in  AWIDTH  execute `ex_o_addr_rd`
- `ex_i_change_pc`  in  1  execute `ex_o_change_pc`
- `ex_i_next_pc`  in  PC_WIDTH  execute `ex_next_pc`
- `ex_i_mem_req`  in  1  execute `ex_stall_from_alu`
- `mem_i_ack`  in  1  memory access complete
- `ctl_o_ce`  out  1  to `ex_i_ce`
- `ctl_o_stall`  out  1  to `ex_i_stall`
- `ctl_o_flush`  out  1  to `ex_i_flush`
- `ctl_o_fetch_stall`, `ctl_o_decode_stall`  out  1  hold upstream stages
- `ctl_o_decode_flush`  out  1  invalidate decode contents
- `ctl_o_redirect`  out  1  registered one-cycle pulse: load PC
- `ctl_o_redirect_pc`  out  PC_WIDTH  redirect target, held until next redirect
- `ctl_o_mem_timeout`  out  1  registered one-cycle pulse
- `ctl_o_state`  out  2  current FSM state
- `ctl_o_stall_cnt`  out  16  saturating count of cycles with `ctl_o_decode_stall`=1

## Operation
- **Hazard:** `hazard` = `ex_i_load` & `ex_i_addr_rd`≠0 & ((`de_i_use_rs1` & rs1==rd) | (`de_i_use_rs2` & rs2==rd)). It is combinational.
- **FSM:** RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is illegal and returns to RUN.
- **RUN outputs:**
  - `ctl_o_ce` = `de_i_valid` & !hazard & !`ex_i_change_pc` & !`ex_i_mem_req`
  - `ctl_o_flush` = `ctl_o_decode_flush` = `ex_i_change_pc`
  - fetch/decode stall = (hazard | `ex_i_mem_req`) & !`ex_i_change_pc`
  - `ctl_o_stall` = 0
- **RUN transitions** (priority: change_pc > mem_req > hazard):
  - On `ex_i_change_pc`: go to FLUSH; load `flush_cnt` with `FLUSH_CYCLES`-1; register `ex_i_next_pc` into `ctl_o_redirect_pc`; pulse `ctl_o_redirect` next cycle.
  - On `ex_i_mem_req`: go to MEM_WAIT with `timer`=0.
  - A hazard inserts exactly one bubble. Execute clears its opcode when ce=0, so the hazard drops the next cycle.
- **MEM_WAIT outputs:** `ctl_o_ce`=0, `ctl_o_stall`=1, fetch/decode stall=1. `timer` increments each cycle.
- **MEM_WAIT transitions:**
  - `mem_i_ack` → RUN.
  - Otherwise `timer`==`MEM_TIMEOUT`-1 → RUN and pulse `ctl_o_mem_timeout`.
  - If ack and timeout coincide, ack wins and there is no pulse.
  - `ex_i_change_pc` is ignored in this state.
- **FLUSH outputs:** `ctl_o_ce`=0, `ctl_o_flush`=1, `ctl_o_decode_flush`=1, all stalls 0.
- **FLUSH transitions:** `flush_cnt`==0 → RUN, else decrement. `ex_i_change_pc` and `ex_i_mem_req` are ignored.
- **Stall counter:** `ctl_o_stall_cnt` increments on each cycle with `ctl_o_decode_stall`=1 and saturates at 16'hFFFF.

## Timing
- **Reset:** while `ex_rst`=0, state=RUN and every output is 0, including the combinational ones (forced). `ctl_o_redirect_pc`=0, counters=0. Assert mid-operation aborts MEM_WAIT/FLUSH immediately with no pulses.
- **Latencies:**
  - hazard/ce/stall/flush outputs: 0 cycles from inputs (combinational in RUN)
  - state, redirect, timeout pulse: 1 cycle
- **Flush length:** `ctl_o_flush` is high for the change_pc cycle plus `FLUSH_CYCLES` FLUSH cycles.
- **Memory wait:** the mem_req cycle plus up to `MEM_TIMEOUT` MEM_WAIT cycles.
- **Redirect:** `ctl_o_redirect` is high exactly in the first FLUSH cycle.

## Structure
- `header.vh` gains `CTL_RUN`, `CTL_MEM_WAIT`, `CTL_FLUSH` and `CTL_STATE_WIDTH`=2.
- One sub-module is natural: `load_use_detect`, the pure combinational hazard compare. The FSM, timer, flush counter and stall counter stay in `execute_ctrl`.

## Test plan
- **Reset:** drive all inputs 1 with `ex_rst`=0 → every output 0. Release → state 0, `ctl_o_ce` follows `de_i_valid`.
- **Load-use:** `ex_i_load`=1, rd=5, rs1=5, use_rs1=1, valid=1 → ce=0, fetch/decode stall=1 for one cycle. rd=0 → no stall.
- **Branch:** `ex_i_change_pc`=1, next_pc=0x100 with `FLUSH_CYCLES`=2 → flush high 3 cycles, redirect pulse in cycle+1 with pc 0x100, then RUN.
- **Memory ack:** mem_req, ack after 4 cycles → stall high 5 cycles, ce=0 throughout, no timeout, `ctl_o_stall_cnt`=5.
- **Memory timeout:** mem_req, no ack, `MEM_TIMEOUT`=15 → one `ctl_o_mem_timeout` pulse after 15 wait cycles. Ack exactly at the 15th cycle → no pulse.
- **Priority and abort:** change_pc and mem_req together → FLUSH taken. Reset asserted in MEM_WAIT → immediate RUN with outputs 0.
